// File: rtl/clock_time_keeper_pkg.sv
// Shared clock encodings, field limits and widths.
// Used by the time keeper, the mode selector and the display stage.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;
    localparam logic [SEC_W-1:0]  MAX_SEC  = 6'd59;

    // 24-hour value (0..23) to 12-hour display value (1..12)
    function automatic logic [HOUR_W-1:0] to_12h(input logic [HOUR_W-1:0] h);
        if (h == '0)
            return 5'd12;
        else if (h > 5'd12)
            return h - 5'd12;
        else
            return h;
    endfunction

endpackage

// File: rtl/clock_time_keeper_if.sv
// Mode/pulse inputs and time/display outputs of the time keeper.
// The pm signal exists only with CLOCK_TIME_KEEPER_12H_EN defined.
interface clock_time_keeper_if;
    import clock_pkg::*;

    logic [1:0]        mode;
    logic              inc_pulse;
    logic [HOUR_W-1:0] hours;
    logic [MIN_W-1:0]  minutes;
    logic [SEC_W-1:0]  seconds;
    logic              tick_1hz;
    logic              blink;
`ifdef CLOCK_TIME_KEEPER_12H_EN
    logic              pm;
`endif

    modport master (
`ifdef CLOCK_TIME_KEEPER_12H_EN
        input  pm,
`endif
        output mode, inc_pulse,
        input  hours, minutes, seconds, tick_1hz, blink
    );

    modport slave (
`ifdef CLOCK_TIME_KEEPER_12H_EN
        output pm,
`endif
        input  mode, inc_pulse,
        output hours, minutes, seconds, tick_1hz, blink
    );

endinterface

// File: rtl/clock_time_keeper_tick_gen_1hz.sv
// 1 Hz prescaler: counts 0..CLK_FREQ_HZ-1, flags mid-second and last cycle.
// A synchronous clear restarts the second from zero.
module tick_gen_1hz #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int CNT_W = $clog2(CLK_FREQ_HZ);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLK_FREQ_HZ - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_FREQ_HZ / 2 - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // next count: clear wins, otherwise wrap at the last cycle of the second
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || cnt_q == LAST)
            cnt_d = '0;
    end

    // prescaler register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign half_tick = (cnt_q == HALF_LAST);
    assign full_tick = (cnt_q == LAST);

endmodule

// File: rtl/clock_time_keeper.sv
// HH:MM:SS keeper with per-field SET modes and edit blink flag.
// Optional 12-hour display via CLOCK_TIME_KEEPER_12H_EN.
module clock_time_keeper
    import clock_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input logic                 clk,
    input logic                 rst_n,
    clock_time_keeper_if.slave  bus
);

    localparam int HOLD_W = $clog2(CLK_FREQ_HZ / 2 + 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(CLK_FREQ_HZ / 2);

    logic [HOUR_W-1:0] hours_q, hours_d;
    logic [MIN_W-1:0]  mins_q, mins_d;
    logic [SEC_W-1:0]  secs_q, secs_d;
    logic              blink_q, blink_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              was_set_q;
    logic              run, set_h, set_m, set_s;
    logic              clear, half_tick, full_tick, tick;

    assign run   = (bus.mode == MODE_RUN);
    assign set_h = (bus.mode == MODE_SET_HOUR);
    assign set_m = (bus.mode == MODE_SET_MIN);
    assign set_s = (bus.mode == MODE_SET_SEC);

    // restart the second on the first RUN cycle after editing
    assign clear = run && was_set_q;
    assign tick  = run && full_tick && !clear;

    tick_gen_1hz #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    // time fields: carry chain on a RUN tick, single-field step in SET
    always_comb begin
        hours_d = hours_q;
        mins_d  = mins_q;
        secs_d  = secs_q;
        if (tick) begin
            if (secs_q == MAX_SEC) begin
                secs_d = '0;
                if (mins_q == MAX_MIN) begin
                    mins_d  = '0;
                    hours_d = (hours_q == MAX_HOUR) ? '0 : hours_q + 5'd1;
                end else begin
                    mins_d = mins_q + 6'd1;
                end
            end else begin
                secs_d = secs_q + 6'd1;
            end
        end else if (bus.inc_pulse) begin
            if (set_h)
                hours_d = (hours_q == MAX_HOUR) ? '0 : hours_q + 5'd1;
            if (set_m)
                mins_d = (mins_q == MAX_MIN) ? '0 : mins_q + 6'd1;
            if (set_s)
                secs_d = (secs_q == MAX_SEC) ? '0 : secs_q + 6'd1;
        end
    end

    // blink: half-second square wave, held dark for a half-period after a step
    always_comb begin
        blink_d = blink_q;
        hold_d  = hold_q;
        if (run) begin
            blink_d = 1'b0;
            hold_d  = '0;
        end else if (bus.inc_pulse) begin
            blink_d = 1'b0;
            hold_d  = HOLD_INIT;
        end else if (hold_q != '0) begin
            blink_d = 1'b0;
            hold_d  = hold_q - HOLD_W'(1);
        end else if (half_tick || full_tick) begin
            blink_d = ~blink_q;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hours_q   <= '0;
            mins_q    <= '0;
            secs_q    <= '0;
            blink_q   <= 1'b0;
            hold_q    <= '0;
            was_set_q <= 1'b0;
        end else begin
            hours_q   <= hours_d;
            mins_q    <= mins_d;
            secs_q    <= secs_d;
            blink_q   <= blink_d;
            hold_q    <= hold_d;
            was_set_q <= !run;
        end
    end

`ifdef CLOCK_TIME_KEEPER_12H_EN
    assign bus.hours = to_12h(hours_q);
    assign bus.pm    = (hours_q >= 5'd12);
`else
    assign bus.hours = hours_q;
`endif
    assign bus.minutes  = mins_q;
    assign bus.seconds  = secs_q;
    assign bus.tick_1hz = tick;
    assign bus.blink    = blink_q && !run;

endmodule
